// File: rtl/cursor_move_ctrl.sv
// Cursor step sequencer: encoder/button decode, request arbitration, move pulses.
// Latency: encoder SYNC_STAGES+3 cycles, button SYNC_STAGES+DEBOUNCE+3 cycles.
// Backpressure: requests wait in pending flags while busy; a repeat on a set flag is dropped.
module cursor_move_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 50000,
  parameter int HOLDOFF     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rot_a,
  input  logic       rot_b,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [1:0] move,
  output logic       busy,
  output logic       drop,
  output logic       enc_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [1:0] MV_UP   = 2'b10;
  localparam logic [1:0] MV_DN   = 2'b01;
  localparam logic [1:0] MV_HOLD = 2'b00;

  localparam int              HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLDOFF - 1);
  localparam logic [15:0]     DB_LAST   = 16'(DEBOUNCE - 1);

  // Input bundle bit order: {rot_a, rot_b, btn_inc, btn_dec}
  logic [3:0] sync_q [SYNC_STAGES];
  logic [1:0] ab;
  logic [1:0] btn_lvl;

  // Decoder state
  logic              dec_init;
  logic [1:0]        prev_ab;
  logic signed [3:0] acc;
  logic signed [3:0] acc_step;
  logic              step_cw;
  logic              step_ccw;
  logic              step_bad;
  logic              enc_inc_req;
  logic              enc_dec_req;

  // Debouncers, index 1 = inc button, index 0 = dec button
  logic [15:0] db_cnt [2];
  logic [1:0]  db_lvl;
  logic [1:0]  db_lvl_d;
  logic [1:0]  btn_req;

  // Pending flags, bit order {enc_inc, enc_dec, btn_inc, btn_dec}
  logic [3:0] pend;
  logic [3:0] req_vec;
  logic [3:0] cancel_vec;
  logic [3:0] avail;
  logic [3:0] grant;
  logic [3:0] clear_vec;
  logic [3:0] pend_next;
  logic       enc_cancel;
  logic       btn_cancel;
  logic       drop_next;

  // Arbiter FSM
  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    move_next;

  assign ab      = sync_q[SYNC_STAGES-1][3:2];
  assign btn_lvl = sync_q[SYNC_STAGES-1][1:0];

  // Synchronizer chain; encoder rests at 11, buttons at released
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1100;
    end else begin
      sync_q[0] <= {rot_a, rot_b, btn_inc, btn_dec};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Classify the quadrature transition and compute the saturated accumulator step
  always_comb begin
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    step_bad = 1'b0;
    case ({prev_ab, ab})
      4'b1101, 4'b0100, 4'b0010, 4'b1011: step_cw  = 1'b1;
      4'b1110, 4'b1000, 4'b0001, 4'b0111: step_ccw = 1'b1;
      4'b1100, 4'b0011, 4'b0110, 4'b1001: step_bad = 1'b1;
      default: ;
    endcase
    acc_step = acc;
    if (step_cw && (acc != 4'sd4))
      acc_step = acc + 4'sd1;
    else if (step_ccw && (acc != -4'sd4))
      acc_step = acc - 4'sd1;
  end

  // Quadrature decoder: one request per full detent, checked on return to 11
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_init    <= 1'b1;
      prev_ab     <= 2'b11;
      acc         <= 4'sd0;
      enc_inc_req <= 1'b0;
      enc_dec_req <= 1'b0;
      enc_err     <= 1'b0;
    end else begin
      enc_inc_req <= 1'b0;
      enc_dec_req <= 1'b0;
      enc_err     <= 1'b0;
      if (dec_init) begin
        dec_init <= 1'b0;
        prev_ab  <= ab;
      end else if (step_bad) begin
        enc_err <= 1'b1;
        acc     <= 4'sd0;
        prev_ab <= ab;
      end else if (step_cw || step_ccw) begin
        prev_ab <= ab;
        if (ab == 2'b11) begin
          acc         <= 4'sd0;
          enc_inc_req <= (acc_step == 4'sd4);
          enc_dec_req <= (acc_step == -4'sd4);
        end else begin
          acc <= acc_step;
        end
      end
    end
  end

  // Button debounce: accept a new level after it has differed for DEBOUNCE cycles, request on press
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) db_cnt[i] <= 16'd0;
      db_lvl   <= 2'b00;
      db_lvl_d <= 2'b00;
      btn_req  <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_lvl[i] == db_lvl[i]) begin
          db_cnt[i] <= 16'd0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= 16'd0;
          db_lvl[i] <= btn_lvl[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
      db_lvl_d <= db_lvl;
      btn_req  <= db_lvl & ~db_lvl_d;
    end
  end

  // Pending-flag bookkeeping, cancellation and fixed-priority grant
  always_comb begin
    req_vec    = {enc_inc_req, enc_dec_req, btn_req[1], btn_req[0]};
    enc_cancel = pend[3] & pend[2];
    btn_cancel = pend[1] & pend[0];
    cancel_vec = {enc_cancel, enc_cancel, btn_cancel, btn_cancel};
    avail      = pend & ~cancel_vec;
    grant      = 4'b0000;
    if (state == ST_IDLE) begin
      if (avail[3])      grant = 4'b1000;
      else if (avail[2]) grant = 4'b0100;
      else if (avail[1]) grant = 4'b0010;
      else if (avail[0]) grant = 4'b0001;
    end
    clear_vec = grant | cancel_vec;
    pend_next = req_vec | (pend & ~clear_vec);
    drop_next = (|(req_vec & pend & ~clear_vec)) | enc_cancel | btn_cancel;
  end

  // Next-state and move code for the arbiter
  always_comb begin
    next_state = state;
    move_next  = MV_HOLD;
    case (state)
      ST_IDLE: begin
        if (|grant) begin
          next_state = ST_ISSUE;
          move_next  = (grant[3] | grant[1]) ? MV_UP : MV_DN;
        end
      end
      ST_ISSUE: next_state = ST_HOLD;
      ST_HOLD:  if (hold_cnt == HOLD_LAST) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Registered state, flags and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      move     <= MV_HOLD;
      busy     <= 1'b0;
      drop     <= 1'b0;
      pend     <= 4'b0000;
    end else begin
      state <= next_state;
      move  <= move_next;
      busy  <= (next_state != ST_IDLE);
      drop  <= drop_next;
      pend  <= pend_next;
      if (state == ST_HOLD)
        hold_cnt <= hold_cnt + 1'b1;
      else
        hold_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cursor_move_ctrl.sv
// Bench for cursor_move_ctrl: expected events queued at stimulus time, matched at negedge.
// Timing: inputs change 1 time unit after posedge; outputs sampled at negedge.
// All waits are fixed cycle counts; a watchdog bounds total run time.
module tb_cursor_move_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rot_a = 1'b1;
  logic       rot_b = 1'b1;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic [1:0] move;
  logic       busy;
  logic       drop;
  logic       enc_err;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  logic mon_en = 1'b0;

  int         exp_move_cyc[$];
  logic [1:0] exp_move_val[$];
  int         exp_drop_cyc[$];
  int         exp_err_cyc[$];

  localparam logic [7:0] CW  = 8'b01_00_10_11;
  localparam logic [7:0] CCW = 8'b10_00_01_11;

  cursor_move_ctrl #(.SYNC_STAGES(2), .DEBOUNCE(4), .HOLDOFF(3)) dut (
    .clk(clk), .rst(rst), .rot_a(rot_a), .rot_b(rot_b),
    .btn_inc(btn_inc), .btn_dec(btn_dec),
    .move(move), .busy(busy), .drop(drop), .enc_err(enc_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int actual, input int expected);
    n_chk++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_neg(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic set_ab(input logic [1:0] v);
    rot_a = v[1];
    rot_b = v[0];
  endtask

  // Apply four encoder states, each gap cycles after the previous one
  task automatic enc_steps(input logic [7:0] seq, input int gap);
    for (int i = 3; i >= 0; i--) begin
      repeat (gap) tick();
      set_ab(seq[i*2 +: 2]);
    end
  endtask

  task automatic expect_move(input int at, input logic [1:0] v);
    exp_move_cyc.push_back(at);
    exp_move_val.push_back(v);
  endtask

  // Scoreboard: every nonzero move, drop or enc_err must match the head of its queue
  always @(negedge clk) begin
    if (mon_en) begin
      int         ec;
      logic [1:0] ev;
      while (exp_move_cyc.size() > 0 && exp_move_cyc[0] < cyc) begin
        chk("move_missing", cyc, exp_move_cyc[0]);
        ec = exp_move_cyc.pop_front();
        ev = exp_move_val.pop_front();
      end
      while (exp_drop_cyc.size() > 0 && exp_drop_cyc[0] < cyc) begin
        chk("drop_missing", cyc, exp_drop_cyc[0]);
        ec = exp_drop_cyc.pop_front();
      end
      while (exp_err_cyc.size() > 0 && exp_err_cyc[0] < cyc) begin
        chk("err_missing", cyc, exp_err_cyc[0]);
        ec = exp_err_cyc.pop_front();
      end
      if (move != 2'b00) begin
        if (exp_move_cyc.size() == 0) chk("move_unexpected", int'(move), 0);
        else begin
          ec = exp_move_cyc.pop_front();
          ev = exp_move_val.pop_front();
          chk("move_cycle", cyc, ec);
          chk("move_value", int'(move), int'(ev));
        end
      end
      if (drop) begin
        if (exp_drop_cyc.size() == 0) chk("drop_unexpected", 1, 0);
        else begin
          ec = exp_drop_cyc.pop_front();
          chk("drop_cycle", cyc, ec);
        end
      end
      if (enc_err) begin
        if (exp_err_cyc.size() == 0) chk("err_unexpected", 1, 0);
        else begin
          ec = exp_err_cyc.pop_front();
          chk("err_cycle", cyc, ec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p;

    // Reset held 3 cycles with inputs toggling
    for (int i = 0; i < 3; i++) begin
      tick();
      rot_a   = ~rot_a;
      btn_inc = ~btn_inc;
      btn_dec = ~btn_dec;
    end
    set_ab(2'b11);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    rst     = 1'b0;
    mon_en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_move", int'(move), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_drop", int'(drop), 0);
      chk("rst_err", int'(enc_err), 0);
    end
    idle(5);

    // Full CW detent, then full CCW detent, 5 cycles per step
    enc_steps(CW, 5);
    expect_move(cyc + 5, 2'b10);
    idle(20);
    enc_steps(CCW, 5);
    expect_move(cyc + 5, 2'b01);
    idle(20);

    // Partial rotation returns to rest without a move
    idle(5); set_ab(2'b01);
    idle(5); set_ab(2'b11);
    idle(20);

    // Illegal jump 11->00, then legal walk back to 11 without a full detent
    tick(); set_ab(2'b00);
    exp_err_cyc.push_back(cyc + 3);
    idle(5); set_ab(2'b10);
    idle(5); set_ab(2'b11);
    idle(20);

    // Bouncing button, then a stable press; release issues nothing
    for (int i = 0; i < 10; i++) begin
      idle(2);
      btn_inc = ~btn_inc;
    end
    idle(2);
    btn_inc = 1'b1;
    expect_move(cyc + 9, 2'b10);
    idle(20);
    tick(); btn_inc = 1'b0;
    idle(20);

    // Encoder inc and btn_dec requests raised on the same edge
    tick(); btn_dec = 1'b1; p = cyc;
    enc_steps(CW, 1);
    expect_move(p + 9, 2'b10);
    expect_move(p + 14, 2'b01);
    for (int k = 9; k <= 13; k++) begin
      wait_neg(p + k);
      chk("arb_busy", int'(busy), (k < 13) ? 1 : 0);
    end
    tick(); btn_dec = 1'b0;
    idle(20);

    // Second encoder inc while its flag is still pending is dropped
    tick(); btn_inc = 1'b1; p = cyc;
    tick();
    enc_steps(CW, 1);
    enc_steps(CW, 1);
    expect_move(p + 9, 2'b10);
    exp_drop_cyc.push_back(p + 13);
    expect_move(p + 14, 2'b10);
    idle(20);
    tick(); btn_inc = 1'b0;
    idle(20);

    // Encoder inc and dec both pending cancel each other with one drop
    tick(); btn_dec = 1'b1; p = cyc;
    tick();
    enc_steps(CW, 1);
    enc_steps(CCW, 1);
    expect_move(p + 9, 2'b01);
    exp_drop_cyc.push_back(p + 14);
    idle(20);
    tick(); btn_dec = 1'b0;
    idle(20);

    // Reset during HOLD discards the still-pending btn_dec request
    tick(); btn_dec = 1'b1; p = cyc;
    enc_steps(CW, 1);
    idle(4);
    btn_dec = 1'b0;
    expect_move(p + 9, 2'b10);
    idle(2);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hold_move", int'(move), 0);
    chk("rst_hold_busy", int'(busy), 0);
    idle(25);

    chk("move_left", exp_move_cyc.size(), 0);
    chk("drop_left", exp_drop_cyc.size(), 0);
    chk("err_left", exp_err_cyc.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
